// File: rtl/uart_hamming_pkg.sv
// Shared widths and sequencer state encoding for the UART / Hamming(7,4) receive path.
package uart_hamming_pkg;
  localparam int CODE_W = 7;
  localparam int NIB_W  = 4;
  localparam int SYN_W  = 3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_EMIT  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_ISSUE = ST_ISSUE,
    S_WAIT  = ST_WAIT,
    S_EMIT  = ST_EMIT
  } seq_state_e;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with clear; an increment coinciding with a clear lands on 1.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i) begin
      if (clr_i)             cnt_d = CNT_W'(1);
      else if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end else if (clr_i) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/uart_hamming_sequencer.sv
// Sequences UART codewords through the Hamming decoder one at a time and pairs
// the decoded nibbles into bytes on a valid/ready port, with sticky status.
module uart_hamming_sequencer
  import uart_hamming_pkg::*;
#(
  parameter int DEC_TIMEOUT = 8,
  parameter int CNT_W       = 8,
  parameter int MSN_FIRST   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [CODE_W-1:0] rx_code,
  output logic              dec_ena,
  output logic [CODE_W-1:0] dec_code,
  input  logic              dec_valid,
  input  logic [NIB_W-1:0]  dec_data,
  input  logic [SYN_W-1:0]  dec_syndrome,
  output logic [7:0]        byte_data,
  output logic              byte_valid,
  input  logic              byte_ready,
  input  logic              clr_status,
  output logic [CNT_W-1:0]  err_count,
  output logic              overrun,
  output logic              timeout,
  output logic [1:0]        state_out
);
  localparam int TW = (DEC_TIMEOUT > 2) ? $clog2(DEC_TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(DEC_TIMEOUT - 1);

  seq_state_e        state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [NIB_W-1:0]  nib_q, nib_d;
  logic [7:0]        byte_q, byte_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              phase_q, phase_d;
  logic              ovr_q, ovr_d, to_q, to_d;
  logic              err_inc, to_set, ovr_set;

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    nib_d   = nib_q;
    byte_d  = byte_q;
    timer_d = timer_q;
    phase_d = phase_q;
    err_inc = 1'b0;
    to_set  = 1'b0;
    case (state_q)
      S_IDLE: if (rx_valid) begin
        code_d  = rx_code;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (dec_valid) begin
          err_inc = |dec_syndrome;
          if (!phase_q) begin
            nib_d   = dec_data;
            phase_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            byte_d  = (MSN_FIRST != 0) ? {nib_q, dec_data} : {dec_data, nib_q};
            phase_d = 1'b0;
            state_d = S_EMIT;
          end
        end else if (timer_q == T_LAST) begin
          // A half-assembled byte would pair with an unrelated nibble; drop it.
          to_set  = 1'b1;
          phase_d = 1'b0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_EMIT: if (byte_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Sticky flags: a same-cycle set beats a clear.
  assign ovr_set = rx_valid && (state_q != S_IDLE);
  assign ovr_d   = ovr_set | (ovr_q & ~clr_status);
  assign to_d    = to_set  | (to_q  & ~clr_status);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      code_q  <= '0;
      nib_q   <= '0;
      byte_q  <= '0;
      timer_q <= '0;
      phase_q <= 1'b0;
      ovr_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      nib_q   <= nib_d;
      byte_q  <= byte_d;
      timer_q <= timer_d;
      phase_q <= phase_d;
      ovr_q   <= ovr_d;
      to_q    <= to_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (err_inc),
    .clr_i (clr_status),
    .cnt_o (err_count)
  );

  assign dec_ena    = (state_q == S_ISSUE);
  assign dec_code   = code_q;
  assign byte_valid = (state_q == S_EMIT);
  assign byte_data  = byte_q;
  assign overrun    = ovr_q;
  assign timeout    = to_q;
  assign state_out  = state_q;
endmodule

// File: tb/tb_uart_hamming_sequencer.sv
// Scoreboarded random bench: two sequencer instances (MSN-first / narrow counter,
// LSN-first / wide counter) share stimulus and a scripted 2-cycle decoder.
module tb_uart_hamming_sequencer;
  logic       clk = 1'b0;
  logic       rst, rx_valid, dec_valid, byte_ready, clr_status;
  logic [6:0] rx_code;
  logic [3:0] dec_data;
  logic [2:0] dec_syndrome;

  logic       a_dec_ena, a_byte_valid, a_ovr, a_to;
  logic [6:0] a_dec_code;
  logic [7:0] a_byte_data;
  logic [1:0] a_err, a_state;
  logic       b_dec_ena, b_byte_valid, b_ovr, b_to;
  logic [6:0] b_dec_code;
  logic [7:0] b_byte_data, b_err;
  logic [1:0] b_state;

  uart_hamming_sequencer #(.DEC_TIMEOUT(8), .CNT_W(2), .MSN_FIRST(1)) dut_a (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_code(rx_code),
    .dec_ena(a_dec_ena), .dec_code(a_dec_code), .dec_valid(dec_valid),
    .dec_data(dec_data), .dec_syndrome(dec_syndrome), .byte_data(a_byte_data),
    .byte_valid(a_byte_valid), .byte_ready(byte_ready), .clr_status(clr_status),
    .err_count(a_err), .overrun(a_ovr), .timeout(a_to), .state_out(a_state));

  uart_hamming_sequencer #(.DEC_TIMEOUT(8), .CNT_W(8), .MSN_FIRST(0)) dut_b (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_code(rx_code),
    .dec_ena(b_dec_ena), .dec_code(b_dec_code), .dec_valid(dec_valid),
    .dec_data(dec_data), .dec_syndrome(dec_syndrome), .byte_data(b_byte_data),
    .byte_valid(b_byte_valid), .byte_ready(byte_ready), .clr_status(clr_status),
    .err_count(b_err), .overrun(b_ovr), .timeout(b_to), .state_out(b_state));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [7:0] exp_q[$];
  bit         have_first, m_ovr, m_to;
  logic [3:0] first_nib;
  int         m_err_a, m_err_b;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic status(input string tag);
    chk({tag, "/err_a"}, a_err, m_err_a);
    chk({tag, "/err_b"}, b_err, m_err_b);
    chk({tag, "/ovr_a"}, a_ovr, m_ovr);
    chk({tag, "/ovr_b"}, b_ovr, m_ovr);
    chk({tag, "/to_a"}, a_to, m_to);
    chk({tag, "/to_b"}, b_to, m_to);
    chk({tag, "/state_b"}, b_state, a_state === 2'bxx ? 0 : int'(a_state));
  endtask

  task automatic model_reset();
    have_first = 0; m_ovr = 0; m_to = 0; m_err_a = 0; m_err_b = 0;
  endtask

  // One codeword through the decoder; optional silence, consumer stall,
  // codeword fired during EMIT, and status clear on the decoder-answer cycle.
  task automatic codeword(input logic [3:0] nib, input logic [2:0] syn, input bit silent,
                          input int stall, input bit ovr, input bit clr);
    logic [6:0] c;
    bit done;
    c = 7'($urandom);
    done = 0;
    tick(); chk("idle_before", a_state, 0);
    rx_valid = 1; rx_code = c;
    tick(); rx_valid = 0;
    chk("issue_ena_a", a_dec_ena, 1); chk("issue_ena_b", b_dec_ena, 1);
    chk("dec_code_a", a_dec_code, c); chk("dec_code_b", b_dec_code, c);
    chk("issue_state", a_state, 1);
    tick(); chk("ena_one_cycle", a_dec_ena, 0); chk("wait_state", a_state, 2);
    if (silent) begin
      repeat (7) tick();
      chk("still_wait", a_state, 2); chk("to_not_yet", a_to, m_to);
      tick();
      m_to = 1; have_first = 0;
      chk("to_state", a_state, 0);
      status("timeout");
    end else begin
      tick();
      dec_valid = 1; dec_data = nib; dec_syndrome = syn; clr_status = clr;
      if (clr) begin m_err_a = 0; m_err_b = 0; m_ovr = 0; m_to = 0; end
      if (syn != 0) begin
        m_err_a = (m_err_a < 3) ? m_err_a + 1 : 3;
        m_err_b = (m_err_b < 255) ? m_err_b + 1 : 255;
      end
      if (have_first) begin
        exp_q.push_back({first_nib, nib});
        have_first = 0; done = 1;
      end else begin
        first_nib = nib; have_first = 1;
      end
      tick(); dec_valid = 0; clr_status = 0;
      chk("post_dec_state", a_state, done ? 3 : 0);
      chk("byte_valid_lat", a_byte_valid, done ? 1 : 0);
      status("dec");
      if (done) begin
        byte_ready = (stall == 0);
        if (ovr) begin rx_valid = 1; rx_code = 7'($urandom); m_ovr = 1; end
        if (stall == 0) begin
          tick(); rx_valid = 0;
          chk("accept_idle", a_state, 0); chk("drop_no_ena", a_dec_ena, 0);
          if (ovr) status("ovr_accept");
        end else begin
          for (int i = 1; i <= stall; i++) begin
            tick(); rx_valid = 0;
            if (i == 1) begin
              chk("stall_emit", a_state, 3); chk("drop_no_ena", a_dec_ena, 0);
              if (ovr) status("ovr_stall");
            end
          end
          byte_ready = 1;
        end
      end
    end
  endtask

  // Scoreboard monitor: every presented byte must match the oldest expected one.
  always @(negedge clk) begin
    if (!rst && (a_byte_valid || b_byte_valid)) begin
      if (exp_q.size() == 0) begin
        chk("spurious_byte", a_byte_valid | b_byte_valid, 0);
      end else begin
        logic [7:0] e;
        e = exp_q[0];
        chk("byte_valid_a", a_byte_valid, 1);
        chk("byte_valid_b", b_byte_valid, 1);
        chk("byte_a", a_byte_data, e);
        chk("byte_b", b_byte_data, {e[3:0], e[7:4]});
        if (byte_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; rx_valid = 0; rx_code = '0; dec_valid = 0; dec_data = '0;
    dec_syndrome = '0; byte_ready = 0; clr_status = 0;
    model_reset();
    repeat (3) tick();
    chk("rst_state", a_state, 0); chk("rst_ena", a_dec_ena, 0);
    chk("rst_code", a_dec_code, 0); chk("rst_byte", a_byte_data, 0);
    chk("rst_bvalid", a_byte_valid, 0);
    status("rst");
    rst = 0; byte_ready = 1;

    codeword(4'hA, 3'd0, 0, 0, 0, 0);
    codeword(4'h5, 3'd0, 0, 0, 0, 0);
    codeword(4'h1, 3'd0, 0, 0, 0, 0);
    codeword(4'h2, 3'd0, 0, 10, 1, 0);
    codeword(4'h3, 3'd0, 0, 0, 0, 0);
    codeword(4'h4, 3'd0, 0, 0, 0, 0);
    codeword(4'h7, 3'b101, 0, 0, 0, 0);
    codeword(4'h8, 3'b101, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) codeword(4'($urandom), 3'b101, 0, 0, 0, 0);
    codeword(4'hE, 3'd0, 0, 0, 0, 0);
    codeword(4'h6, 3'b011, 0, 0, 0, 1);
    codeword(4'h9, 3'd0, 0, 0, 0, 0);
    codeword(4'h9, 3'd0, 0, 0, 0, 0);
    codeword(4'h0, 3'd0, 1, 0, 0, 0);
    codeword(4'h3, 3'd0, 0, 0, 0, 0);
    codeword(4'hC, 3'd0, 0, 0, 0, 0);

    // Reset while waiting on the decoder with a first nibble stored.
    codeword(4'h7, 3'b001, 0, 0, 0, 0);
    tick(); rx_valid = 1; rx_code = 7'h55;
    tick(); rx_valid = 0;
    tick(); rst = 1; #1;
    chk("async_rst_state", a_state, 0); chk("async_rst_ena", a_dec_ena, 0);
    model_reset();
    tick();
    chk("rstw_code", a_dec_code, 0); chk("rstw_byte", a_byte_data, 0);
    chk("rstw_bvalid", a_byte_valid, 0); chk("rstw_ena", a_dec_ena, 0);
    status("rst_wait");
    rst = 0;
    codeword(4'h6, 3'd0, 0, 0, 0, 0);
    codeword(4'hB, 3'd0, 0, 0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      codeword(4'($urandom), ($urandom_range(2) == 0) ? 3'($urandom_range(7, 1)) : 3'd0,
               $urandom_range(9) == 0, ($urandom_range(2) == 0) ? $urandom_range(4, 1) : 0,
               $urandom_range(4) == 0, $urandom_range(7) == 0);
    end

    repeat (5) tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
